// File: rtl/rv_inst_encoder.sv
// RV32I instruction encoder: turns ID-style ALUop codes plus register/immediate fields into
// 32-bit instruction words and streams them to imem at consecutive word addresses.
module rv_inst_encoder #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 256,
    parameter int BASE   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_inst,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err,
    output logic [1:0]        err_code
);

    // Handshake: a beat moves on an interface only in a cycle where both valid and ready are
    // high at the rising edge; valid never depends on ready, and out_addr/out_inst hold while
    // out_valid && !out_ready.

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_SLL  = 6'd3;
    localparam logic [5:0] OP_JAL  = 6'd4;
    localparam logic [5:0] OP_ADDI = 6'd5;
    localparam logic [5:0] OP_AND  = 6'd6;
    localparam logic [5:0] OP_OR   = 6'd7;
    localparam logic [5:0] OP_XOR  = 6'd8;
    localparam logic [5:0] OP_BLT  = 6'd9;
    localparam logic [5:0] OP_BEQ  = 6'd10;
    localparam logic [5:0] OP_SRL  = 6'd11;
    localparam logic [5:0] OP_LW   = 6'd12;
    localparam logic [5:0] OP_SW   = 6'd13;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_OP    = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;
    localparam logic [1:0] ERR_ODD   = 2'b11;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE);

    logic signed [31:0] imm_s;
    logic               fits_i;
    logic               fits_b;
    logic               fits_j;
    logic [31:0]        enc_inst;
    logic [1:0]         enc_code;
    logic [ADDR_W-3:0]  slot;
    logic [ADDR_W-1:0]  slot_addr;
    logic               full_pending;
    logic               accept;
    logic               xfer;

    assign imm_s  = in_imm;
    assign fits_i = (imm_s >= -32'sd2048)    && (imm_s <= 32'sd2047);
    assign fits_b = (imm_s >= -32'sd4096)    && (imm_s <= 32'sd4094);
    assign fits_j = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574);

    // Branch/jump offsets are checked for alignment before range.
    always_comb begin
        enc_inst = '0;
        enc_code = ERR_NONE;
        case (in_op)
            OP_ADD:  enc_inst = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, OPC_R};
            OP_SUB:  enc_inst = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, OPC_R};
            OP_SLL:  enc_inst = {7'b0000000, in_rs2, in_rs1, 3'b001, in_rd, OPC_R};
            OP_SRL:  enc_inst = {7'b0000000, in_rs2, in_rs1, 3'b101, in_rd, OPC_R};
            OP_XOR:  enc_inst = {7'b0000000, in_rs2, in_rs1, 3'b100, in_rd, OPC_R};
            OP_OR:   enc_inst = {7'b0000000, in_rs2, in_rs1, 3'b110, in_rd, OPC_R};
            OP_AND:  enc_inst = {7'b0000000, in_rs2, in_rs1, 3'b111, in_rd, OPC_R};
            OP_ADDI: begin
                enc_inst = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_I};
                if (!fits_i) enc_code = ERR_RANGE;
            end
            OP_LW: begin
                enc_inst = {in_imm[11:0], in_rs1, 3'b010, in_rd, OPC_LOAD};
                if (!fits_i) enc_code = ERR_RANGE;
            end
            OP_SW: begin
                enc_inst = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OPC_STORE};
                if (!fits_i) enc_code = ERR_RANGE;
            end
            OP_BEQ, OP_BLT: begin
                enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                            (in_op == OP_BLT) ? 3'b100 : 3'b000,
                            in_imm[4:1], in_imm[11], OPC_BRANCH};
                if (in_imm[0])    enc_code = ERR_ODD;
                else if (!fits_b) enc_code = ERR_RANGE;
            end
            OP_JAL: begin
                enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
                if (in_imm[0])    enc_code = ERR_ODD;
                else if (!fits_j) enc_code = ERR_RANGE;
            end
            default: enc_code = ERR_OP;
        endcase
    end

    // Words accepted so far equals count plus the one possibly waiting in the output register.
    assign full_pending = (count + {{ADDR_W{1'b0}}, out_valid}) == DEPTH_C;
    assign in_ready     = !start && !full_pending && (!out_valid || out_ready);
    assign accept       = in_valid && in_ready;
    assign xfer         = out_valid && out_ready;
    assign slot_addr    = BASE_A + {slot, 2'b00};
    assign full         = (count == DEPTH_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_addr  <= BASE_A;
            out_inst  <= '0;
            count     <= '0;
            slot      <= '0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
        end else if (start) begin
            out_valid <= 1'b0;
            count     <= '0;
            slot      <= '0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            if (xfer) count <= count + 1'b1;
            if (accept && enc_code == ERR_NONE) begin
                out_valid <= 1'b1;
                out_addr  <= slot_addr;
                out_inst  <= enc_inst;
                slot      <= slot + 1'b1;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
            // A rejected input is consumed; only the first error code of a run is kept.
            if (accept && enc_code != ERR_NONE) begin
                err <= 1'b1;
                if (!err) err_code <= enc_code;
            end
        end
    end

endmodule

// File: tb/tb_rv_inst_encoder.sv
// Bench for rv_inst_encoder: directed cases plus random traffic checked cycle by cycle against
// a field-level reference model with an expected-word queue.
module tb_rv_inst_encoder;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;
    localparam int BASE   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [5:0]        in_op = '0;
    logic [4:0]        in_rd = '0;
    logic [4:0]        in_rs1 = '0;
    logic [4:0]        in_rs2 = '0;
    logic [31:0]       in_imm = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ADDR_W-1:0] out_addr;
    logic [31:0]       out_inst;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;
    logic [1:0]        err_code;

    rv_inst_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_inst(out_inst),
        .count(count), .full(full), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [ADDR_W+31:0] exp_q[$];
    logic [ADDR_W+31:0] xfer_log[$];
    int                 m_count;
    int                 m_slot;
    bit                 m_err;
    int                 m_code;

    int imm_edges [0:18] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096,
                             -1048577, -1048576, 1048574, 1048575, 1048576, 0, 1, -1, 8, -4};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fld(input logic [31:0] x, input int hi, input int lo);
        return (x >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
    endfunction

    // Reference encoding built from field values and shifts.
    function automatic logic [31:0] ref_inst(input int op, input int rd, input int rs1,
                                             input int rs2, input logic [31:0] imm);
        logic [31:0] r;
        logic [31:0] regs;
        regs = (32'(rs2) << 20) + (32'(rs1) << 15);
        r = 0;
        case (op)
            1:  r = regs + (32'(rd) << 7) + 32'h33;
            2:  r = (32'h20 << 25) + regs + (32'(rd) << 7) + 32'h33;
            3:  r = regs + (32'd1 << 12) + (32'(rd) << 7) + 32'h33;
            11: r = regs + (32'd5 << 12) + (32'(rd) << 7) + 32'h33;
            8:  r = regs + (32'd4 << 12) + (32'(rd) << 7) + 32'h33;
            7:  r = regs + (32'd6 << 12) + (32'(rd) << 7) + 32'h33;
            6:  r = regs + (32'd7 << 12) + (32'(rd) << 7) + 32'h33;
            5:  r = (fld(imm, 11, 0) << 20) + (32'(rs1) << 15) + (32'(rd) << 7) + 32'h13;
            12: r = (fld(imm, 11, 0) << 20) + (32'(rs1) << 15) + (32'd2 << 12) + (32'(rd) << 7) + 32'h03;
            13: r = (fld(imm, 11, 5) << 25) + regs + (32'd2 << 12) + (fld(imm, 4, 0) << 7) + 32'h23;
            9, 10: r = (fld(imm, 12, 12) << 31) + (fld(imm, 10, 5) << 25) + regs
                       + ((op == 9 ? 32'd4 : 32'd0) << 12) + (fld(imm, 4, 1) << 8)
                       + (fld(imm, 11, 11) << 7) + 32'h63;
            4:  r = (fld(imm, 20, 20) << 31) + (fld(imm, 10, 1) << 21) + (fld(imm, 11, 11) << 20)
                    + (fld(imm, 19, 12) << 12) + (32'(rd) << 7) + 32'h6F;
            default: r = 0;
        endcase
        return r;
    endfunction

    function automatic int ref_code(input int op, input logic [31:0] imm);
        int s;
        s = $signed(imm);
        case (op)
            1, 2, 3, 6, 7, 8, 11: return 0;
            5, 12, 13: return (s < -2048 || s > 2047) ? 2 : 0;
            9, 10:     return imm[0] ? 3 : ((s < -4096 || s > 4094) ? 2 : 0);
            4:         return imm[0] ? 3 : ((s < -1048576 || s > 1048574) ? 2 : 0);
            default:   return 1;
        endcase
    endfunction

    function automatic logic [31:0] pick_imm();
        case ($urandom_range(0, 3))
            0:       return 32'(imm_edges[$urandom_range(0, 18)]);
            1:       return 32'(int'($urandom_range(0, 8191)) - 4096);
            2:       return 32'(int'($urandom_range(0, 4095)) - 2048);
            default: return $urandom;
        endcase
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_count = 0;
        m_slot  = 0;
        m_err   = 0;
        m_code  = 0;
    endtask

    // One clock: drive at negedge, check all outputs against the model, advance the model.
    task automatic step(input bit st, input bit iv, input int op, input int rd, input int rs1,
                        input int rs2, input logic [31:0] imm, input bit ordy);
        bit exp_rdy;
        bit pend;
        int code;
        @(negedge clk);
        start = st; in_valid = iv; in_op = 6'(op); in_rd = 5'(rd); in_rs1 = 5'(rs1);
        in_rs2 = 5'(rs2); in_imm = imm; out_ready = ordy;
        #1;
        pend    = (exp_q.size() != 0);
        exp_rdy = !st && (m_count + int'(pend) != DEPTH) && (!pend || ordy);
        check("in_ready", in_ready, exp_rdy);
        check("out_valid", out_valid, pend);
        if (pend) begin
            check("out_addr", out_addr, exp_q[0][ADDR_W+31:32]);
            check("out_inst", out_inst, exp_q[0][31:0]);
        end
        check("count", count, m_count);
        check("full", full, m_count == DEPTH);
        check("err", err, m_err);
        check("err_code", err_code, m_code);
        if (st) begin
            model_clear();
        end else begin
            if (pend && ordy) begin
                xfer_log.push_back({out_addr, out_inst});
                void'(exp_q.pop_front());
                m_count++;
            end
            if (iv && exp_rdy) begin
                code = ref_code(op, imm);
                if (code != 0) begin
                    if (!m_err) m_code = code;
                    m_err = 1;
                end else begin
                    exp_q.push_back({ADDR_W'(BASE + 4 * m_slot), ref_inst(op, rd, rs1, rs2, imm)});
                    m_slot++;
                end
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input bit ordy);
        step(0, 0, 0, 0, 0, 0, 32'd0, ordy);
    endtask

    initial begin
        int base_ix;
        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_addr", out_addr, BASE);
        check("rst_out_inst", out_inst, 0);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_err", err, 0);
        check("rst_err_code", err_code, 0);
        rst = 1'b0;
        model_clear();

        // First add: latency one, address BASE
        base_ix = xfer_log.size();
        step(0, 1, 1, 3, 1, 2, 32'd0, 1);
        idle(1);
        #1;
        check("add_inst", xfer_log[base_ix][31:0], 32'h002081B3);
        check("add_addr", xfer_log[base_ix][ADDR_W+31:32], BASE);
        check("add_count", count, 1);

        // Back-to-back mixed formats
        step(1, 0, 0, 0, 0, 0, 32'd0, 1);
        base_ix = xfer_log.size();
        step(0, 1, 5, 5, 0, 0, 32'hFFFFFFFF, 1);
        step(0, 1, 13, 0, 1, 2, 32'd8, 1);
        step(0, 1, 10, 0, 1, 2, 32'hFFFFFFFC, 1);
        step(0, 1, 4, 1, 0, 0, 32'd8, 1);
        idle(1);
        #1;
        check("addi_inst", xfer_log[base_ix][31:0], 32'hFFF00293);
        check("sw_inst", xfer_log[base_ix+1][31:0], 32'h0020A423);
        check("beq_inst", xfer_log[base_ix+2][31:0], 32'hFE208EE3);
        check("jal_inst", xfer_log[base_ix+3][31:0], 32'h008000EF);
        check("jal_addr", xfer_log[base_ix+3][ADDR_W+31:32], BASE + 12);
        check("full_after4", full, 1);

        // Output stall with input pressure
        step(1, 0, 0, 0, 0, 0, 32'd0, 1);
        step(0, 1, 2, 7, 8, 9, 32'd0, 1);
        repeat (3) step(0, 1, 6, 4, 5, 6, 32'd0, 0);
        #1;
        check("stall_count", count, 0);
        check("stall_inst", out_inst, 32'h409403B3);
        idle(1);

        // First error is kept
        step(1, 0, 0, 0, 0, 0, 32'd0, 1);
        step(0, 1, 0, 1, 1, 1, 32'd0, 1);
        #1;
        check("illegal_err", err, 1);
        check("illegal_code", err_code, 2'b01);
        step(0, 1, 5, 1, 1, 0, 32'd2048, 1);
        #1;
        check("code_kept", err_code, 2'b01);
        check("err_nothing_out", out_valid, 0);
        step(0, 1, 1, 2, 3, 4, 32'd0, 1);
        idle(1);
        #1;
        check("slot_unchanged", xfer_log[xfer_log.size()-1][ADDR_W+31:32], BASE);

        // Odd offset, then jal range
        step(1, 0, 0, 0, 0, 0, 32'd0, 1);
        step(0, 1, 10, 0, 1, 2, 32'd3, 1);
        #1;
        check("odd_code", err_code, 2'b11);
        step(1, 0, 0, 0, 0, 0, 32'd0, 1);
        step(0, 1, 4, 1, 0, 0, 32'd1048576, 1);
        #1;
        check("range_code", err_code, 2'b10);

        // Six pushes into a depth-four run
        step(1, 0, 0, 0, 0, 0, 32'd0, 1);
        for (int i = 0; i < 6; i++) step(0, 1, 8, i, i + 1, i + 2, 32'd0, 1);
        idle(1);
        #1;
        check("push6_full", full, 1);
        check("push6_count", count, DEPTH);
        check("push6_last_addr", xfer_log[xfer_log.size()-1][ADDR_W+31:32], BASE + 12);

        // Start during a stall drops the pending word
        step(1, 0, 0, 0, 0, 0, 32'd0, 0);
        step(0, 1, 7, 1, 2, 3, 32'd0, 0);
        idle(0);
        step(1, 0, 0, 0, 0, 0, 32'd0, 0);
        #1;
        check("start_drop_valid", out_valid, 0);
        check("start_drop_count", count, 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 15),
                 $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                 pick_imm(), $urandom_range(0, 9) < 7);
        end
        idle(1);
        idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
